arb_mux_reg: RTL and testbench

//  Registered N:1 data multiplexer with per-channel valid/ready handshake and built-in arbitration.

---
 rtl/mux_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 54 +++++
 rtl/arb_mux_reg.sv | 85 ++++++++
 tb/tb_arb_mux_reg.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the arbitrated registered multiplexer.
package mux_pkg;

    typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_t;

    // Widest request vector onehot2idx can encode; callers zero-extend to this.
    localparam int unsigned MAX_N = 64;

    function automatic int unsigned onehot2idx(input logic [MAX_N-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (oh[i]) idx |= i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter with selectable fixed-priority or round-robin policy.
// The round-robin pointer moves past the winner only when the grant is used.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter arb_mode_t   MODE = ARB_RR,
    localparam int unsigned IW  = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] cand;
    logic          found;

    // Scan N candidates starting at the pointer (or at 0 for fixed priority).
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (MODE == ARB_RR) ? IW'((32'(ptr_q) + k) % N) : IW'(k);
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign gnt_idx = IW'(onehot2idx(MAX_N'(gnt)));

    always_comb begin
        ptr_d = ptr_q;
        if (adv) begin
            ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/arb_mux_reg.sv
// Registered N:1 multiplexer with valid/ready per channel, built-in arbitration
// and a one-deep output register that supports back-to-back transfers.
module arb_mux_reg
    import mux_pkg::*;
#(
    parameter int unsigned W    = 4,
    parameter int unsigned N    = 4,
    parameter arb_mode_t   MODE = ARB_RR,
    localparam int unsigned IW  = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [IW-1:0]  out_ch,
    input  logic           out_ready
);

    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          load;
    logic          xfer;
    logic [W-1:0]  mux_data;

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q,  out_data_d;
    logic [IW-1:0] out_ch_q,    out_ch_d;

    rr_arbiter #(
        .N    (N),
        .MODE (MODE)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (in_valid),
        .adv     (xfer),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign load = !out_valid_q || out_ready;
    // Gating with rst_n keeps every producer stalled while reset is held.
    assign in_ready = gnt & {N{load & rst_n}};
    assign xfer     = |in_ready;

    always_comb begin
        mux_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            mux_data |= in_data[i*W +: W] & {W{gnt[i]}};
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = mux_data;
                out_ch_d   = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Bench for arb_mux_reg: a round-robin and a fixed-priority instance share the
// same stimulus and are compared against a behavioural model of both policies.
module tb_arb_mux_reg;
    import mux_pkg::*;

    localparam int W = 4;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic           out_ready;

    // index 0: round-robin instance, index 1: fixed-priority instance
    logic [N-1:0] rdy [2];
    logic         ov  [2];
    logic [W-1:0] od  [2];
    logic [1:0]   oc  [2];

    int checks = 0;
    int errors = 0;

    logic         mv [2];
    logic [W-1:0] md [2];
    logic [1:0]   mc [2];
    int           mp [2];
    int           mg;

    always #10 clk = ~clk;

    arb_mux_reg #(.W(W), .N(N), .MODE(ARB_RR)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ch(oc[0]),
        .out_ready(out_ready)
    );

    arb_mux_reg #(.W(W), .N(N), .MODE(ARB_FIXED)) dut_fx (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ch(oc[1]),
        .out_ready(out_ready)
    );

    // Winner under each policy: first valid channel scanning upward from the
    // pointer (round-robin) or from channel 0 (fixed); -1 when nobody is valid.
    function automatic int pick(int m);
        int base;
        base = (m == 0) ? mp[0] : 0;
        for (int k = 0; k < N; k++) begin
            if (in_valid[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_rdy(int m);
        int g;
        if (!rst_n) return '0;
        if (mv[m] && !out_ready) return '0;
        g = pick(m);
        if (g < 0) return '0;
        return N'(1 << g);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                mv[m] = 1'b0; md[m] = '0; mc[m] = '0; mp[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (!mv[m] || out_ready) begin
                    mg = pick(m);
                    if (mg >= 0) begin
                        md[m] = in_data[mg*W +: W];
                        mc[m] = 2'(mg);
                        mv[m] = 1'b1;
                        mp[m] = (mg + 1) % N;
                    end else begin
                        mv[m] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        in_data   = 16'($urandom);
        out_ready = 1'b1;
        #15;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (ov[m] !== 1'b0 || od[m] !== 4'h0 || rdy[m] !== 4'h0) begin
                errors++;
                $display("FAIL reset_hold m%0d got v=%b d=%h rdy=%b exp v=0 d=0 rdy=0000",
                         m, ov[m], od[m], rdy[m]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (ov[m] !== 1'b1 || oc[m] !== 2'd0 || od[m] !== in_data[3:0]) begin
                errors++;
                $display("FAIL reset_release m%0d got v=%b ch=%0d d=%h exp v=1 ch=0 d=%h",
                         m, ov[m], oc[m], od[m], in_data[3:0]);
            end
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        in_valid       = 4'b0100;
        in_data        = 16'($urandom);
        in_data[11:8]  = 4'hA;
        out_ready      = 1'b1;
        #5;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (rdy[m] !== 4'b0100) begin
                errors++;
                $display("FAIL single_ready m%0d got %b exp 0100", m, rdy[m]);
            end
        end
        @(posedge clk); #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (ov[m] !== 1'b1 || od[m] !== 4'hA || oc[m] !== 2'd2) begin
                errors++;
                $display("FAIL single_out m%0d got v=%b d=%h ch=%0d exp v=1 d=a ch=2",
                         m, ov[m], od[m], oc[m]);
            end
        end
    endtask

    task automatic test_round_robin_and_fixed();
        logic [N*W-1:0] dat;
        logic [1:0]     ech;
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        dat       = 16'($urandom);
        in_data   = dat;
        out_ready = 1'b1;
        #4 rst_n = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rdy[0] !== N'(1 << (c % N)) || rdy[1] !== 4'b0001) begin
                errors++;
                $display("FAIL stream_ready c%0d got rr=%b fx=%b exp rr=%b fx=0001",
                         c, rdy[0], rdy[1], N'(1 << (c % N)));
            end
            @(posedge clk); #1;
            ech = 2'(c % N);
            checks++;
            if (oc[0] !== ech || od[0] !== dat[ech*W +: W] || ov[0] !== 1'b1) begin
                errors++;
                $display("FAIL rr_seq c%0d got ch=%0d d=%h exp ch=%0d d=%h",
                         c, oc[0], od[0], ech, dat[ech*W +: W]);
            end
            checks++;
            if (oc[1] !== 2'd0 || od[1] !== dat[3:0] || ov[1] !== 1'b1) begin
                errors++;
                $display("FAIL fixed_seq c%0d got ch=%0d d=%h exp ch=0 d=%h",
                         c, oc[1], od[1], dat[3:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] hd [2];
        logic [1:0]   hc [2];
        logic [1:0]   nxt;
        out_ready = 1'b0;
        for (int m = 0; m < 2; m++) begin
            hd[m] = od[m];
            hc[m] = oc[m];
        end
        nxt = 2'((int'(hc[0]) + 1) % N);
        for (int c = 0; c < 3; c++) begin
            #1;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (rdy[m] !== 4'h0) begin
                    errors++;
                    $display("FAIL bp_ready m%0d c%0d got %b exp 0000", m, c, rdy[m]);
                end
            end
            @(posedge clk); #1;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (ov[m] !== 1'b1 || od[m] !== hd[m] || oc[m] !== hc[m]) begin
                    errors++;
                    $display("FAIL bp_hold m%0d c%0d got v=%b d=%h ch=%0d exp v=1 d=%h ch=%0d",
                             m, c, ov[m], od[m], oc[m], hd[m], hc[m]);
                end
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (rdy[0] !== N'(1 << nxt) || rdy[1] !== 4'b0001) begin
            errors++;
            $display("FAIL bp_release_ready got rr=%b fx=%b exp rr=%b fx=0001",
                     rdy[0], rdy[1], N'(1 << nxt));
        end
        @(posedge clk); #1;
        checks++;
        if (oc[0] !== nxt || oc[1] !== 2'd0) begin
            errors++;
            $display("FAIL bp_release_ch got rr=%0d fx=%0d exp rr=%0d fx=0",
                     oc[0], oc[1], nxt);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        #2 rst_n = 1'b1;
        @(negedge clk);
        in_valid = 4'b0010;
        in_data  = 16'($urandom);
        @(posedge clk); #1;
        checks++;
        if (oc[0] !== 2'd1 || ov[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup got ch=%0d v=%b exp ch=1 v=1", oc[0], ov[0]);
        end
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (ov[m] !== 1'b0 || od[m] !== 4'h0 || oc[m] !== 2'd0 || rdy[m] !== 4'h0) begin
                errors++;
                $display("FAIL mid_reset m%0d got v=%b d=%h ch=%0d rdy=%b exp all zero",
                         m, ov[m], od[m], oc[m], rdy[m]);
            end
        end
        #4 rst_n = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        #1;
        checks++;
        if (rdy[0] !== 4'b0001) begin
            errors++;
            $display("FAIL mid_restart_ready got %b exp 0001", rdy[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (oc[0] !== 2'd0 || ov[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_restart_ch got ch=%0d v=%b exp ch=0 v=1", oc[0], ov[0]);
        end
    endtask

    task automatic test_random(int cycles);
        logic [N-1:0] er;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            in_valid  = 4'($urandom);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            #5;
            for (int m = 0; m < 2; m++) begin
                er = exp_rdy(m);
                checks++;
                if (rdy[m] !== er) begin
                    errors++;
                    $display("FAIL rand_ready m%0d c%0d got %b exp %b", m, c, rdy[m], er);
                end
            end
            @(posedge clk); #1;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (ov[m] !== mv[m] || od[m] !== md[m] || oc[m] !== mc[m]) begin
                    errors++;
                    $display("FAIL rand_out m%0d c%0d got v=%b d=%h ch=%0d exp v=%b d=%h ch=%0d",
                             m, c, ov[m], od[m], oc[m], mv[m], md[m], mc[m]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin_and_fixed();
        test_backpressure();
        test_reset_mid();
        test_random(300);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
